// File: rtl/debug_snapshot_reader.sv
// -----------------------------------------------------------------------------
// debug_snapshot_reader
//
// Sweeps the 2-bit select of Debug_Interface through 0..3. Each select is held
// for HOLD_CYCLES settle cycles. The byte returned on din is then captured.
// The four bytes are packed into one 32-bit snapshot, {byte3, byte2, byte1,
// byte0}, which is offered to a downstream consumer on a valid/ready handshake.
// Every snapshot that is loaded carries an 8-bit sequence number. A completed
// sweep that cannot be loaded, because the consumer still holds the previous
// snapshot, is dropped and sets a sticky overrun flag.
//
// Parameters
//   HOLD_CYCLES : settle cycles after each dsel change (legal 1..15)
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous reset, active-low
//   start      in   1  request one sweep (looked at only while idle)
//   continuous in   1  at sweep completion, start the next sweep at once
//   din        in   8  byte from Debug_Interface.dout
//   dsel       out  2  select to Debug_Interface (registered)
//   busy       out  1  a sweep is in progress
//   snap_valid out  1  snapshot available
//   snap_ready in   1  consumer accepts the snapshot
//   snap_data  out 32  snapshot {byte3, byte2, byte1, byte0}
//   snap_seq   out  8  sequence number of the presented snapshot
//   overrun    out  1  sticky: a completed sweep was dropped
//   clear_ovr  in   1  clears overrun (a drop at the same edge wins)
// -----------------------------------------------------------------------------
module debug_snapshot_reader #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        continuous,
  input  logic [7:0]  din,
  output logic [1:0]  dsel,
  output logic        busy,
  output logic        snap_valid,
  input  logic        snap_ready,
  output logic [31:0] snap_data,
  output logic [7:0]  snap_seq,
  output logic        overrun,
  input  logic        clear_ovr
);

  // Out-of-range settings are pulled into 1..15 so that the 4-bit settle
  // counter always reaches its terminal value.
  localparam int HOLD_EFF =
    (HOLD_CYCLES < 1)  ? 1  :
    (HOLD_CYCLES > 15) ? 15 : HOLD_CYCLES;
  localparam logic [3:0] CNT_LAST = 4'(HOLD_EFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic [7:0] shadow [4];

  logic xfer;       // consumer takes the presented snapshot at this edge
  logic load_ok;    // the snapshot register is free, or is freed at this edge
  logic last_byte;  // the current byte is byte3

  assign xfer      = snap_valid & snap_ready;
  assign load_ok   = ~snap_valid | snap_ready;
  assign last_byte = (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= 4'd0;
      dsel       <= 2'd0;
      busy       <= 1'b0;
      snap_valid <= 1'b0;
      snap_data  <= 32'h0000_0000;
      snap_seq   <= 8'h00;
      overrun    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= 8'h00;
      end
    end else begin
      // Handshake and overrun clear first. The completion branch below
      // overrides them when it loads or drops at the same edge.
      if (xfer) begin
        snap_valid <= 1'b0;
      end
      if (clear_ovr) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            idx   <= 2'd0;
            cnt   <= 4'd0;
            dsel  <= 2'd0;
            busy  <= 1'b1;
            state <= SETTLE;
          end
        end

        SETTLE: begin
          // dsel has been stable since the edge that entered SETTLE.
          // After HOLD_EFF full cycles the byte is sampled on the next edge.
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          shadow[idx] <= din;
          if (!last_byte) begin
            idx   <= idx + 2'd1;
            dsel  <= idx + 2'd1;
            cnt   <= 4'd0;
            state <= SETTLE;
          end else begin
            // byte3 is taken directly from din. It is not written to the
            // shadow bytes first, so the snapshot can load on this edge.
            if (load_ok) begin
              snap_data  <= {din, shadow[2], shadow[1], shadow[0]};
              snap_valid <= 1'b1;
              snap_seq   <= snap_seq + 8'd1;
            end else begin
              overrun <= 1'b1;
            end
            idx <= 2'd0;
            cnt <= 4'd0;
            if (continuous) begin
              dsel  <= 2'd0;
              state <= SETTLE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_snapshot_reader.sv
// -----------------------------------------------------------------------------
// tb_debug_snapshot_reader
//
// Directed bench for debug_snapshot_reader.
// dut1 uses HOLD_CYCLES=1. Its din follows the pattern base + dsel.
// dut2 uses HOLD_CYCLES=3. Its din comes from a small Debug_Interface model
// with Ain=15, Bin=4, ALUout=8 and ALUop=4.
// Inputs change on the falling edge. Outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_debug_snapshot_reader;

  logic clk;
  logic rst_n;

  // dut1 signals
  logic        start, continuous, snap_ready, clear_ovr;
  logic [7:0]  din;
  logic [1:0]  dsel;
  logic        busy, snap_valid, overrun;
  logic [31:0] snap_data;
  logic [7:0]  snap_seq;
  logic [7:0]  base;

  // dut2 signals
  logic        start2, continuous2, snap_ready2, clear_ovr2;
  logic [7:0]  din2;
  logic [1:0]  dsel2;
  logic        busy2, snap_valid2, overrun2;
  logic [31:0] snap_data2;
  logic [7:0]  snap_seq2;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_seq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign din = base + {6'b0, dsel};

  // Debug_Interface model: 0->Ain, 1->Bin, 2->ALUout, 3->ALUop
  function automatic logic [7:0] dbg_dout(input logic [1:0] s);
    case (s)
      2'd0:    dbg_dout = 8'd15;
      2'd1:    dbg_dout = 8'd4;
      2'd2:    dbg_dout = 8'd8;
      default: dbg_dout = 8'd4;
    endcase
  endfunction
  assign din2 = dbg_dout(dsel2);

  debug_snapshot_reader #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .din(din), .dsel(dsel), .busy(busy), .snap_valid(snap_valid),
    .snap_ready(snap_ready), .snap_data(snap_data), .snap_seq(snap_seq),
    .overrun(overrun), .clear_ovr(clear_ovr)
  );

  debug_snapshot_reader #(.HOLD_CYCLES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .continuous(continuous2),
    .din(din2), .dsel(dsel2), .busy(busy2), .snap_valid(snap_valid2),
    .snap_ready(snap_ready2), .snap_data(snap_data2), .snap_seq(snap_seq2),
    .overrun(overrun2), .clear_ovr(clear_ovr2)
  );

  typedef struct {
    logic [7:0]  base;
    logic [31:0] exp_data;
    logic [7:0]  exp_seq;
    bit          mid_start;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // The caller has already raised start before the falling edge that starts
  // this wait. This task drops start and stops on the first falling edge
  // where snap_valid is high. It returns the latency in cycles, or -1 if the
  // bound runs out.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (snap_valid) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  // One single-shot sweep on dut1, including the dsel trace and the accept.
  task automatic run_sweep(input vec_t v);
    int lat;
    logic [15:0] trace;
    lat = -1;
    trace = 16'h0;
    base = v.base;
    start = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (v.mid_start && k == 3) start = 1'b1;
      if (v.mid_start && k == 4) start = 1'b0;
      if (k <= 8) trace = trace | (16'(dsel) << (2 * (k - 1)));
      if (snap_valid) begin
        lat = k - 1;
        break;
      end
    end
    start = 1'b0;
    $display("[TB] sweep base=%h lat=%0d data=%h seq=%0d dsel_trace=%h",
             v.base, lat, snap_data, snap_seq, trace);
    check("sweep_latency", 32'(lat), 32'd8);
    check("sweep_dsel_trace", {16'h0, trace}, 32'h0000_FA50);
    check("sweep_data", snap_data, v.exp_data);
    check("sweep_seq", {24'h0, snap_seq}, {24'h0, v.exp_seq});
    check("sweep_busy_done", {31'h0, busy}, 32'd0);
    snap_ready = 1'b1;
    tick(1);
    snap_ready = 1'b0;
    check("sweep_valid_after_accept", {31'h0, snap_valid}, 32'd0);
    check("sweep_busy_after", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int last_k;
    int snaps;
    logic [31:0] trace2;
    bit done;

    vecs[0] = '{base: 8'hA0, exp_data: 32'hA3A2A1A0, exp_seq: 8'd1, mid_start: 1'b0};
    vecs[1] = '{base: 8'h10, exp_data: 32'h13121110, exp_seq: 8'd2, mid_start: 1'b1};
    vecs[2] = '{base: 8'hFC, exp_data: 32'hFFFEFDFC, exp_seq: 8'd3, mid_start: 1'b0};
    vecs[3] = '{base: 8'h00, exp_data: 32'h03020100, exp_seq: 8'd4, mid_start: 1'b1};

    rst_n = 1'b0;
    start = 1'b0; continuous = 1'b0; snap_ready = 1'b0; clear_ovr = 1'b0;
    start2 = 1'b0; continuous2 = 1'b0; snap_ready2 = 1'b0; clear_ovr2 = 1'b0;
    base = 8'hA0;
    exp_seq = 8'd0;

    tick(3);
    check("rst_dsel", {30'h0, dsel}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_valid", {31'h0, snap_valid}, 32'd0);
    check("rst_data", snap_data, 32'd0);
    check("rst_seq", {24'h0, snap_seq}, 32'd0);
    check("rst_overrun", {31'h0, overrun}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Table-driven single sweeps. Two of them pulse start mid-sweep.
    for (int i = 0; i < 4; i++) begin
      run_sweep(vecs[i]);
      tick(2);
    end
    exp_seq = 8'd4;

    // dut2 with HOLD_CYCLES=3, reading from the Debug_Interface model
    trace2 = 32'h0;
    lat = -1;
    start2 = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 1) start2 = 1'b0;
      if (k <= 16) trace2 = trace2 | (32'(dsel2) << (2 * (k - 1)));
      if (snap_valid2) begin
        lat = k - 1;
        break;
      end
    end
    $display("[TB] hold3 sweep lat=%0d data=%h seq=%0d", lat, snap_data2, snap_seq2);
    check("hold3_latency", 32'(lat), 32'd16);
    check("hold3_dsel_trace", trace2, 32'hFFAA5500);
    check("hold3_data", snap_data2, 32'h0408040F);
    check("hold3_seq", {24'h0, snap_seq2}, 32'd1);
    check("hold3_busy_done", {31'h0, busy2}, 32'd0);
    snap_ready2 = 1'b1;
    tick(1);
    snap_ready2 = 1'b0;
    check("hold3_valid_after_accept", {31'h0, snap_valid2}, 32'd0);

    // Continuous mode with snap_ready held at 1: one snapshot every 8 cycles,
    // and snap_seq wraps.
    base = 8'hA0;
    continuous = 1'b1;
    snap_ready = 1'b1;
    start = 1'b1;
    last_k = 1;
    snaps = 0;
    done = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (snap_valid) begin
        exp_seq = exp_seq + 8'd1;
        snaps++;
        $display("[TB] cont snapshot %0d seq=%0d data=%h gap=%0d", snaps, snap_seq, snap_data, k - last_k);
        check("cont_gap", 32'(k - last_k), 32'd8);
        check("cont_seq", {24'h0, snap_seq}, {24'h0, exp_seq});
        last_k = k;
        if (snaps == 258) continuous = 1'b0;
      end
      if (!continuous && !busy && !snap_valid) begin
        done = 1'b1;
        break;
      end
    end
    check("cont_terminated", {31'h0, done}, 32'd1);
    check("cont_wrapped", {31'h0, (snaps > 256)}, 32'd1);
    check("cont_overrun", {31'h0, overrun}, 32'd0);
    snap_ready = 1'b0;
    tick(2);

    // Continuous mode with snap_ready=0: hold, drop, overrun clear rules
    base = 8'hA0;
    continuous = 1'b1;
    start = 1'b1;
    wait_valid(lat);
    exp_seq = exp_seq + 8'd1;
    $display("[TB] stall first snapshot lat=%0d data=%h seq=%0d", lat, snap_data, snap_seq);
    check("stall_latency", 32'(lat), 32'd8);
    check("stall_data", snap_data, 32'hA3A2A1A0);
    check("stall_seq", {24'h0, snap_seq}, {24'h0, exp_seq});
    base = 8'h50;
    tick(7);
    check("stall_ovr_before_drop", {31'h0, overrun}, 32'd0);
    tick(1);
    $display("[TB] stall drop overrun=%0d data=%h seq=%0d", overrun, snap_data, snap_seq);
    check("drop_overrun", {31'h0, overrun}, 32'd1);
    check("drop_data_held", snap_data, 32'hA3A2A1A0);
    check("drop_seq_held", {24'h0, snap_seq}, {24'h0, exp_seq});
    check("drop_valid_held", {31'h0, snap_valid}, 32'd1);
    clear_ovr = 1'b1;
    tick(1);
    clear_ovr = 1'b0;
    check("clear_no_drop", {31'h0, overrun}, 32'd0);
    tick(6);
    clear_ovr = 1'b1;
    tick(1);
    clear_ovr = 1'b0;
    check("clear_with_drop", {31'h0, overrun}, 32'd1);
    check("clear_with_drop_data", snap_data, 32'hA3A2A1A0);
    tick(7);
    // Accept and load at the same edge
    snap_ready = 1'b1;
    continuous = 1'b0;
    tick(1);
    exp_seq = exp_seq + 8'd1;
    $display("[TB] accept+load valid=%0d data=%h seq=%0d", snap_valid, snap_data, snap_seq);
    check("acc_load_valid", {31'h0, snap_valid}, 32'd1);
    check("acc_load_data", snap_data, 32'h53525150);
    check("acc_load_seq", {24'h0, snap_seq}, {24'h0, exp_seq});
    check("acc_load_busy", {31'h0, busy}, 32'd0);
    tick(1);
    snap_ready = 1'b0;
    check("acc_load_drain", {31'h0, snap_valid}, 32'd0);
    clear_ovr = 1'b1;
    tick(1);
    clear_ovr = 1'b0;

    // Reset while idx=2
    base = 8'hA0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    check("pre_reset_dsel", {30'h0, dsel}, 32'd2);
    rst_n = 1'b0;
    #1;
    $display("[TB] mid-sweep reset dsel=%0d busy=%0d seq=%0d data=%h", dsel, busy, snap_seq, snap_data);
    check("mrst_dsel", {30'h0, dsel}, 32'd0);
    check("mrst_busy", {31'h0, busy}, 32'd0);
    check("mrst_valid", {31'h0, snap_valid}, 32'd0);
    check("mrst_data", snap_data, 32'd0);
    check("mrst_seq", {24'h0, snap_seq}, 32'd0);
    check("mrst_overrun", {31'h0, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("mrst_no_emit", {31'h0, snap_valid}, 32'd0);
    run_sweep('{base: 8'h21, exp_data: 32'h24232221, exp_seq: 8'd1, mid_start: 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_snapshot_reader.md
# debug_snapshot_reader

Reads the 8-bit `dout` of `Debug_Interface` by sweeping its `dsel` select through 0..3 and capturing each byte. It assembles the four bytes into one 32-bit snapshot and presents it on a valid/ready handshake to a downstream consumer such as a UART framer or a register file. It sits between `Debug_Interface` and the debug export path, and is the only driver of `dsel`.

## Interface
- `HOLD_CYCLES`, default 1: settle cycles after each `dsel` change before `din` is sampled. Legal range is 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `start` in 1: request one sweep. Sampled only in IDLE.
- `continuous` in 1: when 1 at sweep completion, the next sweep starts immediately.
- `din` in 8: byte from `Debug_Interface.dout`.
- `dsel` out 2: select to `Debug_Interface`. Registered.
- `busy` out 1: high while a sweep is in progress.
- `snap_valid` out 1: a snapshot is available.
- `snap_ready` in 1: the consumer accepts the snapshot.
- `snap_data` out 32: the snapshot, `{byte3, byte2, byte1, byte0}`. Byte k is captured with `dsel` = k.
- `snap_seq` out 8: sequence number of the presented snapshot.
- `overrun` out 1: sticky flag. A completed sweep was dropped.
- `clear_ovr` in 1: clears `overrun`.

## Operation
- State machine states: IDLE, SETTLE, SAMPLE.
- IDLE:
  - `busy`=0.
  - `start`=1 at an edge sets `idx`=0 and `cnt`=0, and moves to SETTLE.
- SETTLE:
  - `busy`=1 and `dsel`=`idx`.
  - `cnt` increments each cycle. When `cnt` = `HOLD_CYCLES`-1 at an edge, the state moves to SAMPLE.
- SAMPLE:
  - At the edge, `din` is written into shadow byte `idx`.
  - If `idx` < 3: `idx` increments, `cnt` is set to 0, and the state moves to SETTLE.
  - If `idx` = 3: the sweep is complete (completion rules below).
- Completion, on the SAMPLE edge with `idx` = 3:
  - Load condition: `snap_valid`=0, or `snap_valid` & `snap_ready`=1 at the same edge.
  - If the load condition holds: `snap_data` takes the shadow bytes with byte3 taken from `din` at this edge, `snap_valid`=1, and `snap_seq` increments (wraps 255→0).
  - Otherwise: the sweep is dropped, `overrun` is set to 1, and `snap_data`, `snap_seq` and `snap_valid` are unchanged.
  - Next state: if `continuous`=1, `idx`=0, `cnt`=0 and the state is SETTLE; otherwise the state is IDLE and `idx`=0.
- `start` while `busy`=1 is ignored.
- Changing `continuous` mid-sweep has no effect until the completion edge.
- Handshake:
  - A transfer occurs at an edge with `snap_valid` & `snap_ready` = 1.
  - After a transfer, `snap_valid` falls unless a new load happens at the same edge; in that case it stays 1 with new data.
  - `snap_data` and `snap_seq` are stable while `snap_valid`=1 and no transfer has occurred.
  - `snap_ready` while `snap_valid`=0 has no effect.
- `overrun`:
  - Set on a drop, cleared by `clear_ovr`=1 at an edge.
  - A simultaneous drop and clear leaves `overrun`=1.
- Reset values: state IDLE, `idx`=0, `cnt`=0, `dsel`=0, `busy`=0, `snap_valid`=0, `snap_data`=0, `snap_seq`=0, `overrun`=0, shadow bytes 0.
- Reset mid-sweep discards the partial capture. No snapshot is emitted.

## Timing
- `dsel` changes only on the edge that enters SETTLE. `din` is sampled no earlier than `HOLD_CYCLES` full cycles after `dsel` changes.
- Per-byte cost is `HOLD_CYCLES`+1 cycles.
- Latency: with `start` sampled at edge E0, `snap_valid` rises after edge E0 + 4·(`HOLD_CYCLES`+1). With the default this is 8 cycles.
- In continuous mode, sweeps occur back to back every 4·(`HOLD_CYCLES`+1) cycles, with no idle cycle between them.
- `busy` falls on the completion edge when `continuous`=0.
- All outputs are registered. There are no combinational paths from any input to any output.

## Test plan
- Single sweep:
  - Stimulus: model `din` = 8'hA0 + `dsel`, `HOLD_CYCLES`=1, one `start` pulse, `snap_ready`=1 after valid.
  - Required: `dsel` sequence 0,0,1,1,2,2,3,3; `snap_valid` rises 8 cycles after the `start` edge; `snap_data`=32'hA3A2A1A0; `snap_seq`=1; the block returns to IDLE with `busy`=0.
- `HOLD_CYCLES`=3 with `din` from the real `Debug_Interface` (Ain=15, Bin=4, ALUout=8, ALUop=4):
  - Required: each byte matches `dout` at the corresponding `dsel`; latency is 16 cycles.
- Continuous mode with `snap_ready` held 1:
  - Required: a snapshot every 8 cycles; `snap_seq` runs 1,2,3,…, wraps 255→0 after 256 snapshots; `overrun` stays 0.
- Continuous mode with `snap_ready`=0:
  - Required: the first snapshot is held stable; the second sweep sets `overrun`=1 and does not alter `snap_data`.
  - Then `clear_ovr` with no drop at the same edge: `overrun` returns to 0.
  - Then `clear_ovr` and a drop at the same edge: `overrun` stays 1.
- Handshake and control edge cases:
  - Accept-and-load at the same edge: `snap_valid` stays 1, data is new, `snap_seq` increments.
  - `start` pulsed during a sweep: ignored.
  - `rst_n` asserted while `idx`=2: all outputs return to reset values immediately; a later `start` produces a complete, correct snapshot.
